// File: rtl/dma_priority.sv
// dma_priority: DREQ conditioning, mask/software merge, fixed or rotating arbitration.
// Optional macro DMA_DREQ_SYNC2_EN: two-flop DREQ synchronizer instead of one stage.
module dma_priority (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] DREQ,
    input  logic [7:0] commandReg,
    input  logic [3:0] maskReg,
    input  logic [3:0] requestReg,
    input  logic       hrq,
    input  logic       HLDA,
    input  logic       validDACK,
    input  logic       tc,
    output logic [3:0] VALID_DREQ,
    output logic [3:0] DACK,
    output logic [1:0] activeCh,
    output logic [3:0] clrReq
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] valid_q, valid_d;
    logic [1:0] act_q, act_d;
    logic [3:0] ack_q, ack_d;
    logic [3:0] clr_q, clr_d;
    logic [1:0] last_q, last_d;
    logic [3:0] sync1_q;
    logic [3:0] dreq_sync;
    logic [3:0] dreq_s;
    logic [3:0] pend;
    logic       win_found;
    logic [1:0] win_ch;
    logic [1:0] start;
    logic [1:0] idx;
    logic [3:0] act_oh;

    logic unused_cmd;
    assign unused_cmd = ^{commandReg[5], commandReg[3], commandReg[1:0]};

`ifdef DMA_DREQ_SYNC2_EN
    logic [3:0] sync2_q;

    // Two-stage synchronizer for peripherals on an unrelated clock
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= DREQ;
            sync2_q <= sync1_q;
        end
    end

    assign dreq_sync = sync2_q;
`else
    // Single register stage on the raw request lines
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '0;
        end else begin
            sync1_q <= DREQ;
        end
    end

    assign dreq_sync = sync1_q;
`endif

    assign dreq_s = dreq_sync ^ {4{commandReg[6]}};
    assign pend   = (dreq_s & ~maskReg) | requestReg;
    assign act_oh = 4'b0001 << act_q;

    // Search pending channels from the current top-priority slot
    always_comb begin
        win_found = 1'b0;
        win_ch    = 2'd0;
        idx       = 2'd0;
        start     = commandReg[4] ? last_q + 2'd1 : 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!win_found && pend[idx]) begin
                win_found = 1'b1;
                win_ch    = idx;
            end
        end
    end

    // Grant / service sequencing; the grant is frozen once latched
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        act_d   = act_q;
        ack_d   = ack_q;
        clr_d   = 4'b0000;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (!commandReg[2] && win_found) begin
                    valid_d = 4'b0001 << win_ch;
                    act_d   = win_ch;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!HLDA && !pend[act_q]) begin
                    valid_d = 4'b0000;
                    state_d = S_IDLE;
                end else if (validDACK) begin
                    ack_d   = act_oh;
                    state_d = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (tc) begin
                    clr_d = act_oh;
                end
                if (!hrq) begin
                    valid_d = 4'b0000;
                    ack_d   = 4'b0000;
                    last_d  = act_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                valid_d = 4'b0000;
                ack_d   = 4'b0000;
                state_d = S_IDLE;
            end
        endcase
    end

    // Arbiter state and registered outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            act_q   <= '0;
            ack_q   <= '0;
            clr_q   <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            act_q   <= act_d;
            ack_q   <= ack_d;
            clr_q   <= clr_d;
            last_q  <= last_d;
        end
    end

    assign VALID_DREQ = valid_q;
    assign activeCh   = act_q;
    assign clrReq     = clr_q;
    assign DACK       = commandReg[7] ? ack_q : ~ack_q;

endmodule

// File: tb/tb_dma_priority.sv
// tb_dma_priority: directed scenarios plus random traffic
// checked against a cycle-level reference model of the arbiter.
module tb_dma_priority;

`ifdef DMA_DREQ_SYNC2_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] DREQ;
    logic [7:0] commandReg;
    logic [3:0] maskReg;
    logic [3:0] requestReg;
    logic       hrq;
    logic       HLDA;
    logic       validDACK;
    logic       tc;
    logic [3:0] VALID_DREQ;
    logic [3:0] DACK;
    logic [1:0] activeCh;
    logic [3:0] clrReq;

    dma_priority dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .DREQ       (DREQ),
        .commandReg (commandReg),
        .maskReg    (maskReg),
        .requestReg (requestReg),
        .hrq        (hrq),
        .HLDA       (HLDA),
        .validDACK  (validDACK),
        .tc         (tc),
        .VALID_DREQ (VALID_DREQ),
        .DACK       (DACK),
        .activeCh   (activeCh),
        .clrReq     (clrReq)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: granted channel (-1 = none), in-service flag
    int         m_g;
    bit         m_svc;
    int         m_last;
    int         m_act;
    logic [3:0] m_clr;
    logic [3:0] m_dly[2];

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_g      = -1;
        m_svc    = 1'b0;
        m_last   = 3;
        m_act    = 0;
        m_clr    = 4'b0000;
        m_dly[0] = 4'b0000;
        m_dly[1] = 4'b0000;
    endtask

    function automatic logic [3:0] exp_dack(input logic [7:0] cm);
        logic [3:0] a;
        a = (m_g >= 0 && m_svc) ? 4'(1 << m_g) : 4'b0000;
        return cm[7] ? a : ~a;
    endfunction

    task automatic check_all(input string tag);
        logic [3:0] ev;
        ev = (m_g >= 0) ? 4'(1 << m_g) : 4'b0000;
        chk({tag, ".valid"}, VALID_DREQ, ev);
        chk({tag, ".dack"}, DACK, exp_dack(commandReg));
        chk({tag, ".act"}, {2'b00, activeCh}, 4'(m_act));
        chk({tag, ".clr"}, clrReq, m_clr);
    endtask

    // one clock: capture inputs, advance model, compare
    task automatic step();
        logic [3:0] d_in, msk, rq, ds, pend;
        logic [7:0] cm;
        logic       h, hl, vd, t;
        int         ch;
        d_in = DREQ; msk = maskReg; rq = requestReg; cm = commandReg;
        h = hrq; hl = HLDA; vd = validDACK; t = tc;
        @(posedge CLK);
        #1;
        ds   = m_dly[D-1] ^ {4{cm[6]}};
        pend = (ds & ~msk) | rq;
        m_clr = 4'b0000;
        if (m_g < 0) begin
            if (!cm[2] && pend != 0) begin
                for (int i = 0; i < 4; i++) begin
                    ch = cm[4] ? (m_last + 1 + i) % 4 : i;
                    if (pend[ch] && m_g < 0) m_g = ch;
                end
                m_act = m_g;
                m_svc = 1'b0;
            end
        end else if (!m_svc) begin
            if (!hl && !pend[m_g]) m_g = -1;
            else if (vd) m_svc = 1'b1;
        end else begin
            if (t) m_clr = 4'(1 << m_g);
            if (!h) begin
                m_last = m_g;
                m_g    = -1;
                m_svc  = 1'b0;
            end
        end
        m_dly[1] = m_dly[0];
        m_dly[0] = d_in;
        check_all("cyc");
    endtask

    task automatic finish_service();
        DREQ = 4'b0000;
        requestReg = 4'b0000;
        repeat (3) step();
        hrq = 1'b0;
        step();
        chk("end.valid", VALID_DREQ, 4'b0000);
        hrq = 1'b1;
    endtask

    initial begin
        RESET_N = 1'b0;
        DREQ = '0; commandReg = 8'h00; maskReg = '0; requestReg = '0;
        hrq = 1'b1; HLDA = 1'b1; validDACK = 1'b0; tc = 1'b0;
        model_reset();
        #3;
        chk("rst.valid", VALID_DREQ, 4'b0000);
        chk("rst.dack_lo", DACK, 4'b1111);
        chk("rst.act", {2'b00, activeCh}, 4'b0000);
        chk("rst.clr", clrReq, 4'b0000);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        // fixed priority, active-high DACK
        commandReg = 8'h80;
        DREQ = 4'b1010;
        repeat (D + 1) step();
        chk("fix.valid", VALID_DREQ, 4'b0010);
        chk("fix.act", {2'b00, activeCh}, 4'b0001);
        validDACK = 1'b1; step(); validDACK = 1'b0;
        chk("fix.dack", DACK, 4'b0010);
        finish_service();
        chk("fix.dack_off", DACK, 4'b0000);

        // rotating after ch1 served: ch0 wins, then ch1
        commandReg = 8'h90;
        DREQ = 4'b0011;
        repeat (D + 1) step();
        chk("rot.first", VALID_DREQ, 4'b0001);
        validDACK = 1'b1; step(); validDACK = 1'b0;
        hrq = 1'b0; step(); hrq = 1'b1;
        chk("rot.gap", VALID_DREQ, 4'b0000);
        step();
        chk("rot.second", VALID_DREQ, 4'b0010);
        validDACK = 1'b1; step(); validDACK = 1'b0;
        finish_service();

        // withdrawn request with HLDA low
        commandReg = 8'h80;
        HLDA = 1'b0;
        DREQ = 4'b0100;
        repeat (D + 1) step();
        chk("wd.grant", VALID_DREQ, 4'b0100);
        chk("wd.act", {2'b00, activeCh}, 4'b0010);
        DREQ = 4'b0000;
        repeat (D + 1) step();
        chk("wd.valid", VALID_DREQ, 4'b0000);
        chk("wd.dack", DACK, 4'b0000);
        HLDA = 1'b1;
        step();

        // masked software request, tc coincident with hrq fall
        requestReg = 4'b1000;
        maskReg = 4'b1000;
        step();
        chk("sw.grant", VALID_DREQ, 4'b1000);
        validDACK = 1'b1; step(); validDACK = 1'b0;
        chk("sw.dack", DACK, 4'b1000);
        tc = 1'b1; hrq = 1'b0; step();
        chk("sw.clr", clrReq, 4'b1000);
        chk("sw.idle", VALID_DREQ, 4'b0000);
        tc = 1'b0; hrq = 1'b1; requestReg = 4'b0000; maskReg = 4'b0000;
        step();
        chk("sw.clr_once", clrReq, 4'b0000);

        // controller disable
        commandReg = 8'h84;
        DREQ = 4'hF;
        repeat (4) step();
        chk("dis.none", VALID_DREQ, 4'b0000);
        commandReg = 8'h80;
        step();
        chk("dis.ch0", VALID_DREQ, 4'b0001);
        validDACK = 1'b1; step(); validDACK = 1'b0;
        finish_service();

        // async reset in service, then rotation restarts at ch0
        commandReg = 8'h90;
        DREQ = 4'b0001;
        repeat (D + 1) step();
        validDACK = 1'b1; step(); validDACK = 1'b0;
        chk("ar.dack", DACK, 4'b0001);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("ar.valid", VALID_DREQ, 4'b0000);
        chk("ar.dack_off", DACK, 4'b0000);
        chk("ar.act", {2'b00, activeCh}, 4'b0000);
        RESET_N = 1'b1;
        model_reset();
        DREQ = 4'b0101;
        repeat (D + 1) step();
        chk("ar.ch0", VALID_DREQ, 4'b0001);
        validDACK = 1'b1; step(); validDACK = 1'b0;
        finish_service();

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if (n % 60 == 0) begin
                commandReg = 8'h00;
                commandReg[2] = ($urandom_range(0, 4) == 0);
                commandReg[4] = 1'($urandom);
                commandReg[6] = 1'($urandom);
                commandReg[7] = 1'($urandom);
            end
            DREQ       = 4'($urandom);
            maskReg    = 4'($urandom);
            requestReg = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            hrq        = ($urandom_range(0, 9) != 0);
            HLDA       = 1'($urandom);
            validDACK  = ($urandom_range(0, 2) == 0);
            tc         = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
